// File: rtl/redirect_ctrl_pkg.sv
// Shared types for the front-end redirect scheduler:
// redirect causes, their priority ranks and the FSM states.
package redirect_ctrl_pkg;

  typedef enum logic [2:0] {
    CAUSE_NONE    = 3'd0,
    CAUSE_TRAP    = 3'd1,
    CAUSE_FLUSH   = 3'd2,
    CAUSE_MISPRED = 3'd3,
    CAUSE_ILLEGAL = 3'd4,
    CAUSE_RETURN  = 3'd5,
    CAUSE_JUMPL   = 3'd6
  } redirect_cause_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_DRAIN
  } state_t;

  // All decoder causes share one rank.
  function automatic logic [1:0] rank(input redirect_cause_t c);
    logic [1:0] r;
    case (c)
      CAUSE_NONE:  r = 2'd0;
      CAUSE_TRAP:  r = 2'd3;
      CAUSE_FLUSH: r = 2'd2;
      default:     r = 2'd1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/redirect_prio_sel.sv
// Fixed-priority select over trap, flush and decoder redirect requests.
// Decoder requests are considered only while dec_en is high.
module redirect_prio_sel
  import redirect_ctrl_pkg::*;
#(
  parameter int PC_BITS = 32
) (
  input  logic               trap_valid,
  input  logic [PC_BITS-1:0] trap_pc,
  input  logic               flush_valid,
  input  logic [PC_BITS-1:0] flush_pc,
  input  logic               dec_en,
  input  logic               dec_mispred,
  input  logic               dec_illegal,
  input  logic               dec_return,
  input  logic               dec_jumpl,
  input  logic [PC_BITS-1:0] dec_pc,
  output logic               sel_valid,
  output logic [PC_BITS-1:0] sel_pc,
  output redirect_cause_t    sel_cause
);

  always_comb begin
    sel_valid = 1'b1;
    sel_pc    = dec_pc;
    sel_cause = CAUSE_NONE;
    priority case (1'b1)
      trap_valid: begin
        sel_pc    = trap_pc;
        sel_cause = CAUSE_TRAP;
      end
      flush_valid: begin
        sel_pc    = flush_pc;
        sel_cause = CAUSE_FLUSH;
      end
      (dec_en && dec_mispred): sel_cause = CAUSE_MISPRED;
      (dec_en && dec_illegal): sel_cause = CAUSE_ILLEGAL;
      (dec_en && dec_return):  sel_cause = CAUSE_RETURN;
      (dec_en && dec_jumpl):   sel_cause = CAUSE_JUMPL;
      default: begin
        sel_valid = 1'b0;
        sel_pc    = '0;
      end
    endcase
  end

endmodule

// File: rtl/redirect_ctrl.sv
// Front-end redirect scheduler: arbitrates redirect sources, holds one
// redirect for IF, blocks the decoder for a drain window, counts redirects.
module redirect_ctrl
  import redirect_ctrl_pkg::*;
#(
  parameter int PC_BITS      = 32,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               trap_valid_i,
  input  logic [PC_BITS-1:0] trap_pc_i,
  input  logic               flush_valid_i,
  input  logic [PC_BITS-1:0] flush_pc_i,
  input  logic               dec_invalid_prediction_i,
  input  logic               dec_invalid_instruction_i,
  input  logic               dec_is_return_i,
  input  logic               dec_is_jumpl_i,
  input  logic [PC_BITS-1:0] dec_old_pc_i,
  input  logic               if_ready_i,
  output logic               redirect_valid_o,
  output logic [PC_BITS-1:0] redirect_pc_o,
  output logic [2:0]         redirect_cause_o,
  output logic               dec_block_o,
  output logic               busy_o,
  output logic [31:0]        cnt_trap_o,
  output logic [31:0]        cnt_flush_o,
  output logic [31:0]        cnt_dec_o
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

  state_t             state, state_nx;
  logic [PC_BITS-1:0] hold_pc, hold_pc_nx;
  redirect_cause_t    hold_cause, hold_cause_nx;
  logic [DW-1:0]      drain_cnt, drain_cnt_nx;
  logic               accept;
  logic               valid_q, busy_q;
  logic [31:0]        cnt_trap, cnt_flush, cnt_dec;

  logic               sel_valid;
  logic [PC_BITS-1:0] sel_pc;
  redirect_cause_t    sel_cause;

  // Decoder causes in DRAIN come from stale fetches.
  redirect_prio_sel #(
    .PC_BITS(PC_BITS)
  ) u_sel (
    .trap_valid (trap_valid_i),
    .trap_pc    (trap_pc_i),
    .flush_valid(flush_valid_i),
    .flush_pc   (flush_pc_i),
    .dec_en     (state != ST_DRAIN),
    .dec_mispred(dec_invalid_prediction_i),
    .dec_illegal(dec_invalid_instruction_i),
    .dec_return (dec_is_return_i),
    .dec_jumpl  (dec_is_jumpl_i),
    .dec_pc     (dec_old_pc_i),
    .sel_valid  (sel_valid),
    .sel_pc     (sel_pc),
    .sel_cause  (sel_cause)
  );

  always_comb begin
    state_nx      = state;
    hold_pc_nx    = hold_pc;
    hold_cause_nx = hold_cause;
    drain_cnt_nx  = drain_cnt;
    accept        = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (sel_valid) begin
          state_nx      = ST_REQ;
          hold_pc_nx    = sel_pc;
          hold_cause_nx = sel_cause;
        end
      end
      ST_REQ: begin
        if (if_ready_i) begin
          accept       = 1'b1;
          state_nx     = ST_DRAIN;
          drain_cnt_nx = DRAIN_LOAD;
        end else if (sel_valid &&
                     rank(sel_cause) > rank(hold_cause)) begin
          hold_pc_nx    = sel_pc;
          hold_cause_nx = sel_cause;
        end
      end
      ST_DRAIN: begin
        if (sel_valid) begin
          state_nx      = ST_REQ;
          hold_pc_nx    = sel_pc;
          hold_cause_nx = sel_cause;
        end else if (drain_cnt == '0) begin
          state_nx = ST_IDLE;
        end else begin
          drain_cnt_nx = drain_cnt - 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      hold_pc    <= '0;
      hold_cause <= CAUSE_NONE;
      drain_cnt  <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state      <= state_nx;
      hold_pc    <= hold_pc_nx;
      hold_cause <= hold_cause_nx;
      drain_cnt  <= drain_cnt_nx;
      valid_q    <= (state_nx == ST_REQ);
      busy_q     <= (state_nx != ST_IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_trap  <= '0;
      cnt_flush <= '0;
      cnt_dec   <= '0;
    end else if (accept) begin
      unique case (hold_cause)
        CAUSE_TRAP: begin
          if (cnt_trap != '1) cnt_trap <= cnt_trap + 1'b1;
        end
        CAUSE_FLUSH: begin
          if (cnt_flush != '1) cnt_flush <= cnt_flush + 1'b1;
        end
        default: begin
          if (cnt_dec != '1) cnt_dec <= cnt_dec + 1'b1;
        end
      endcase
    end
  end

  assign redirect_valid_o = valid_q;
  assign redirect_pc_o    = hold_pc;
  assign redirect_cause_o = hold_cause;
  assign busy_o           = busy_q;
  assign dec_block_o      = busy_q;
  assign cnt_trap_o       = cnt_trap;
  assign cnt_flush_o      = cnt_flush;
  assign cnt_dec_o        = cnt_dec;

endmodule

// File: tb/tb_redirect_ctrl.sv
// Bench for redirect_ctrl: directed vector table, saturation sequence
// and randomized traffic against a queue-free behavioural model.
module tb_redirect_ctrl;

  localparam int DRAIN = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        trap_valid, flush_valid;
  logic [31:0] trap_pc, flush_pc, dec_pc;
  logic        mis, ill, ret, jl, rdy;
  logic        r_valid, d_block, busy;
  logic [31:0] r_pc, c_trap, c_flush, c_dec;
  logic [2:0]  r_cause;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  redirect_ctrl #(
    .PC_BITS(32),
    .DRAIN_CYCLES(DRAIN)
  ) dut (
    .clk                      (clk),
    .rst                      (rst),
    .trap_valid_i             (trap_valid),
    .trap_pc_i                (trap_pc),
    .flush_valid_i            (flush_valid),
    .flush_pc_i               (flush_pc),
    .dec_invalid_prediction_i (mis),
    .dec_invalid_instruction_i(ill),
    .dec_is_return_i          (ret),
    .dec_is_jumpl_i           (jl),
    .dec_old_pc_i             (dec_pc),
    .if_ready_i               (rdy),
    .redirect_valid_o         (r_valid),
    .redirect_pc_o            (r_pc),
    .redirect_cause_o         (r_cause),
    .dec_block_o              (d_block),
    .busy_o                   (busy),
    .cnt_trap_o               (c_trap),
    .cnt_flush_o              (c_flush),
    .cnt_dec_o                (c_dec)
  );

  typedef struct {
    bit        rst;
    bit        trap;
    bit [31:0] tpc;
    bit        flush;
    bit [31:0] fpc;
    bit [3:0]  dec;
    bit [31:0] dpc;
    bit        rdy;
    bit        ev;
    bit [31:0] epc;
    bit [2:0]  ec;
    bit        eb;
    bit [31:0] ct, cf, cd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    bit r, bit t, bit [31:0] tp, bit f, bit [31:0] fp,
    bit [3:0] d, bit [31:0] dp, bit y,
    bit ev, bit [31:0] epc, bit [2:0] ec, bit eb,
    bit [31:0] ct, bit [31:0] cf, bit [31:0] cd);
    vec_t v;
    v.rst = r; v.trap = t; v.tpc = tp; v.flush = f; v.fpc = fp;
    v.dec = d; v.dpc = dp; v.rdy = y;
    v.ev = ev; v.epc = epc; v.ec = ec; v.eb = eb;
    v.ct = ct; v.cf = cf; v.cd = cd;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    rst = 0; trap_valid = 0; flush_valid = 0;
    trap_pc = 0; flush_pc = 0; dec_pc = 0;
    mis = 0; ill = 0; ret = 0; jl = 0; rdy = 0;
  endtask

  // ---------------- behavioural model ----------------
  bit        m_pend;
  bit [31:0] m_pc;
  bit [2:0]  m_cause;
  int        m_blk;
  bit [31:0] m_ct, m_cf, m_cd;

  function automatic int rk(bit [2:0] c);
    if (c == 3'd1) return 3;
    if (c == 3'd2) return 2;
    if (c == 3'd0) return 0;
    return 1;
  endfunction

  function automatic void pick(input bit use_dec, output bit v,
                               output bit [31:0] pc, output bit [2:0] c);
    bit        r[6];
    bit [31:0] p[6];
    r = '{trap_valid, flush_valid, use_dec && mis, use_dec && ill,
          use_dec && ret, use_dec && jl};
    p = '{trap_pc, flush_pc, dec_pc, dec_pc, dec_pc, dec_pc};
    v = 0; pc = 0; c = 0;
    for (int i = 5; i >= 0; i--)
      if (r[i]) begin v = 1; pc = p[i]; c = 3'(i + 1); end
  endfunction

  function automatic bit [31:0] sat_inc(bit [31:0] x);
    return (x == 32'hFFFF_FFFF) ? x : x + 1;
  endfunction

  function automatic void model_step();
    bit v; bit [31:0] pc; bit [2:0] c;
    if (rst) begin
      m_pend = 0; m_pc = 0; m_cause = 0; m_blk = 0;
      m_ct = 0; m_cf = 0; m_cd = 0;
    end else if (m_pend) begin
      if (rdy) begin
        if (m_cause == 1) m_ct = sat_inc(m_ct);
        else if (m_cause == 2) m_cf = sat_inc(m_cf);
        else m_cd = sat_inc(m_cd);
        m_pend = 0;
        m_blk = DRAIN;
      end else begin
        pick(1, v, pc, c);
        if (v && rk(c) > rk(m_cause)) begin m_pc = pc; m_cause = c; end
      end
    end else if (m_blk > 0) begin
      pick(0, v, pc, c);
      if (v) begin m_pend = 1; m_pc = pc; m_cause = c; m_blk = 0; end
      else m_blk--;
    end else begin
      pick(1, v, pc, c);
      if (v) begin m_pend = 1; m_pc = pc; m_cause = c; end
    end
  endfunction

  initial begin
    vec_t v;
    idle_inputs();
    // rst trap tpc flush fpc dec dpc rdy | ev epc ec eb ct cf cd
    vecs.push_back(mk(1,0,0,0,0,4'h0,0,0, 0,0,0,0, 0,0,0));
    vecs.push_back(mk(0,0,0,0,0,4'h8,32'h1000,1, 1,32'h1000,3,1, 0,0,0));
    vecs.push_back(mk(0,0,0,0,0,4'h0,0,1, 0,0,0,1, 0,0,1));
    vecs.push_back(mk(0,0,0,0,0,4'h0,0,0, 0,0,0,1, 0,0,1));
    vecs.push_back(mk(0,0,0,0,0,4'h0,0,0, 0,0,0,0, 0,0,1));
    vecs.push_back(mk(0,0,0,1,32'h2000,4'h0,0,0, 1,32'h2000,2,1, 0,0,1));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0,0,0,0,0,4'h0,0,0, 1,32'h2000,2,1, 0,0,1));
    vecs.push_back(mk(0,0,0,0,0,4'h0,0,1, 0,0,0,1, 0,1,1));
    vecs.push_back(mk(0,0,0,0,0,4'h0,0,0, 0,0,0,1, 0,1,1));
    vecs.push_back(mk(0,0,0,0,0,4'h0,0,0, 0,0,0,0, 0,1,1));
    vecs.push_back(mk(0,0,0,1,32'h2000,4'h0,0,0, 1,32'h2000,2,1, 0,1,1));
    vecs.push_back(mk(0,1,32'h80,0,0,4'h0,0,0, 1,32'h80,1,1, 0,1,1));
    vecs.push_back(mk(0,0,0,0,0,4'h1,32'h5000,0, 1,32'h80,1,1, 0,1,1));
    vecs.push_back(mk(0,0,0,0,0,4'h0,0,1, 0,0,0,1, 1,1,1));
    vecs.push_back(mk(0,0,0,0,0,4'h0,0,0, 0,0,0,1, 1,1,1));
    vecs.push_back(mk(0,0,0,0,0,4'h0,0,0, 0,0,0,0, 1,1,1));
    vecs.push_back(mk(0,1,32'h80,1,32'h3000,4'h4,32'h6000,0,
                      1,32'h80,1,1, 1,1,1));
    vecs.push_back(mk(0,0,0,0,0,4'h0,0,1, 0,0,0,1, 2,1,1));
    vecs.push_back(mk(0,0,0,0,0,4'h0,0,0, 0,0,0,1, 2,1,1));
    vecs.push_back(mk(0,0,0,0,0,4'h0,0,0, 0,0,0,0, 2,1,1));
    vecs.push_back(mk(0,0,0,0,0,4'h0,0,0, 0,0,0,0, 2,1,1));
    vecs.push_back(mk(0,0,0,0,0,4'h2,32'h7000,1, 1,32'h7000,5,1, 2,1,1));
    vecs.push_back(mk(0,0,0,0,0,4'h0,0,1, 0,0,0,1, 2,1,2));
    vecs.push_back(mk(0,0,0,0,0,4'h8,32'h9000,0, 0,0,0,1, 2,1,2));
    vecs.push_back(mk(0,0,0,0,0,4'h1,32'h9000,0, 0,0,0,0, 2,1,2));
    vecs.push_back(mk(0,0,0,0,0,4'h1,32'h9100,0, 1,32'h9100,6,1, 2,1,2));
    vecs.push_back(mk(0,0,0,0,0,4'h0,0,1, 0,0,0,1, 2,1,3));
    vecs.push_back(mk(0,0,0,1,32'h4000,4'h0,0,0, 1,32'h4000,2,1, 2,1,3));
    vecs.push_back(mk(0,0,0,0,0,4'h0,0,1, 0,0,0,1, 2,2,3));
    vecs.push_back(mk(0,0,0,0,0,4'h0,0,0, 0,0,0,1, 2,2,3));
    vecs.push_back(mk(0,0,0,0,0,4'h0,0,0, 0,0,0,0, 2,2,3));
    vecs.push_back(mk(0,1,32'hA0,0,0,4'h0,0,0, 1,32'hA0,1,1, 2,2,3));
    vecs.push_back(mk(1,0,0,0,0,4'h0,0,1, 0,0,0,0, 0,0,0));
    vecs.push_back(mk(0,0,0,0,0,4'h0,0,0, 0,0,0,0, 0,0,0));

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      rst = v.rst; trap_valid = v.trap; trap_pc = v.tpc;
      flush_valid = v.flush; flush_pc = v.fpc;
      {mis, ill, ret, jl} = v.dec; dec_pc = v.dpc; rdy = v.rdy;
      @(posedge clk); #1;
      check($sformatf("v%0d.valid", i), 32'(r_valid), 32'(v.ev));
      check($sformatf("v%0d.block", i), 32'(d_block), 32'(v.eb));
      check($sformatf("v%0d.busy", i), 32'(busy), 32'(v.eb));
      if (v.ev || v.rst) begin
        check($sformatf("v%0d.pc", i), r_pc, v.epc);
        check($sformatf("v%0d.cause", i), 32'(r_cause), 32'(v.ec));
      end
      check($sformatf("v%0d.ctrap", i), c_trap, v.ct);
      check($sformatf("v%0d.cflush", i), c_flush, v.cf);
      check($sformatf("v%0d.cdec", i), c_dec, v.cd);
    end

    // Saturation: preload the decoder counter, then one more redirect.
    idle_inputs();
    @(negedge clk);
    dut.cnt_dec = 32'hFFFF_FFFF;
    mis = 1; dec_pc = 32'h1000; rdy = 1;
    @(posedge clk); #1;
    idle_inputs(); rdy = 1;
    check("sat.valid", 32'(r_valid), 32'd1);
    @(posedge clk); #1;
    idle_inputs();
    check("sat.cdec", c_dec, 32'hFFFF_FFFF);
    check("sat.ctrap", c_trap, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("sat.idle", 32'(busy), 32'd0);

    // Randomized traffic against the model, starting from reset.
    rst = 1;
    @(posedge clk);
    model_step();
    #1;
    for (int n = 0; n < 4000; n++) begin
      rst         = ($urandom_range(0, 149) == 0);
      trap_valid  = ($urandom_range(0, 11) == 0);
      flush_valid = ($urandom_range(0, 7) == 0);
      mis         = ($urandom_range(0, 9) == 0);
      ill         = ($urandom_range(0, 9) == 0);
      ret         = ($urandom_range(0, 9) == 0);
      jl          = ($urandom_range(0, 9) == 0);
      trap_pc     = $urandom;
      flush_pc    = $urandom;
      dec_pc      = $urandom;
      rdy         = ($urandom_range(0, 1) == 1);
      @(posedge clk);
      model_step();
      #1;
      check("rnd.valid", 32'(r_valid), 32'(m_pend));
      check("rnd.block", 32'(d_block), 32'(m_pend || m_blk > 0));
      check("rnd.busy", 32'(busy), 32'(m_pend || m_blk > 0));
      if (m_pend) begin
        check("rnd.pc", r_pc, m_pc);
        check("rnd.cause", 32'(r_cause), 32'(m_cause));
      end
      check("rnd.ctrap", c_trap, m_ct);
      check("rnd.cflush", c_flush, m_cf);
      check("rnd.cdec", c_dec, m_cd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/redirect_ctrl.md
# redirect_ctrl

Front-end redirect scheduler between the dual-issue decoder, the execute-stage flush path, the trap logic and instruction fetch. It arbitrates all fetch-redirect sources by fixed priority and presents one registered redirect to IF over a valid/ready handshake. After each accepted redirect it blocks the decoder for a fixed drain window so stale fetched instructions are discarded. It also keeps per-source redirect counters for benchmarking.

## Interface
Parameters:
- PC_BITS, 32, PC width.
- DRAIN_CYCLES, 2, number of cycles the decoder stays blocked after a redirect is accepted. Legal range is ≥1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- trap_valid_i  in  1  trap redirect request; priority 1 (highest).
- trap_pc_i  in  PC_BITS  trap vector.
- flush_valid_i  in  1  execute misprediction flush request; priority 2.
- flush_pc_i  in  PC_BITS  corrected PC.
- dec_invalid_prediction_i  in  1  decoder found a taken prediction on a non-branch.
- dec_invalid_instruction_i  in  1  decoder found an illegal or misaligned instruction.
- dec_is_return_i  in  1  decoder issued a return.
- dec_is_jumpl_i  in  1  decoder issued a jump-and-link-register.
- dec_old_pc_i  in  PC_BITS  PC already selected by the decoder for the active decoder cause.
- if_ready_i  in  1  IF accepts the redirect this cycle.
- redirect_valid_o  out  1  redirect pending.
- redirect_pc_o  out  PC_BITS  redirect PC.
- redirect_cause_o  out  3  redirect_cause_t value.
- dec_block_o  out  1  forces the decoder's valid input low.
- busy_o  out  1  FSM is not IDLE.
- cnt_trap_o, cnt_flush_o, cnt_dec_o  out  32 each  accepted-redirect counters; saturate at all-ones.

## Operation
- Cause encoding:
  - NONE=0, TRAP=1, FLUSH=2, MISPRED=3, ILLEGAL=4, RETURN=5, JUMPL=6.
  - Among decoder inputs the order is MISPRED > ILLEGAL > RETURN > JUMPL.
  - Overall priority rank is TRAP > FLUSH > any decoder cause.
- FSM states are IDLE, REQ and DRAIN.
- IDLE:
  - If any source is valid, latch the winner's PC and cause into the holding register and go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - redirect_valid_o=1.
  - redirect_pc_o and redirect_cause_o stay stable until the handshake.
  - A new request of strictly higher rank overwrites the holding register; the state stays REQ. Equal- or lower-rank requests are dropped.
  - Handshake: if redirect_valid_o & if_ready_i, increment the counter for the latched source, load drain_cnt=DRAIN_CYCLES-1 and go to DRAIN.
  - If a higher-rank request arrives in the handshake cycle, the accepted (old) value completes. The new request is taken in the next cycle as from DRAIN.
- DRAIN:
  - redirect_valid_o=0.
  - Decoder inputs are ignored, because they come from stale instructions.
  - trap or flush valid: latch it, go to REQ. The drain window restarts after that handshake.
  - drain_cnt==0: go to IDLE. Otherwise decrement drain_cnt.
- dec_block_o = busy_o = (state != IDLE).
- Counters are 32-bit and hold at 0xFFFFFFFF. The decoder counter counts all four decoder causes.

## Timing
- All outputs are registered.
- Request-to-redirect latency:
  - A request sampled at edge N gives redirect_valid_o=1 after edge N.
  - An immediate if_ready_i makes that handshake cycle N+1.
- DRAIN lasts exactly DRAIN_CYCLES cycles, so dec_block_o stays high for DRAIN_CYCLES cycles after the handshake cycle.
- A decoder request is accepted again in the first IDLE cycle.
- Reset values:
  - state=IDLE.
  - redirect_valid_o=0, redirect_pc_o=0, redirect_cause_o=NONE.
  - dec_block_o=0, busy_o=0.
  - all counters=0, drain_cnt=0.
- rst asserted mid-REQ or mid-DRAIN: the pending redirect is discarded (no counter increment) and all state returns to reset values on the next edge.
- Simultaneous requests from all sources in IDLE: TRAP is latched; the others are dropped.

## Structure
- Shared package holds:
  - the redirect_cause_t enum (3 bits),
  - the rank function mapping cause to priority,
  - the FSM state enum.
- One natural sub-module, redirect_prio_sel: a combinational priority select over trap, flush and decoder inputs, producing {valid, pc, cause}.
- The FSM, holding register, drain counter and stat counters live in redirect_ctrl.

## Test plan
- Single decoder mispredict: pulse dec_invalid_prediction_i with dec_old_pc_i=0x1000, if_ready_i=1.
  - Required: redirect_valid_o=1 for one cycle with pc 0x1000, cause 3.
  - dec_block_o high for 1+2 cycles.
  - cnt_dec_o=1.
- IF backpressure: raise the flush request with pc 0x2000 and hold if_ready_i=0 for 5 cycles.
  - Required: pc and cause stay stable for 5 cycles.
  - Handshake occurs on the 6th cycle; cnt_flush_o=1.
- Preemption in REQ: flush 0x2000 pending; trap with pc 0x80 arrives the next cycle.
  - Required: output switches to 0x80, cause 1.
  - A later decoder jumpl is dropped.
  - Counts: trap=1, flush=0.
- Simultaneous requests: trap 0x80, flush 0x3000 and decoder illegal all raised in the same IDLE cycle.
  - Required: only the trap (0x80) is redirected.
- DRAIN behaviour:
  - A decoder request during DRAIN is ignored and the FSM returns to IDLE after 2 cycles.
  - A flush with pc 0x4000 during DRAIN goes back to REQ with 0x4000.
- Reset and saturation:
  - rst asserted during REQ: all outputs are 0 next cycle and no counter increments.
  - Force cnt_dec to 0xFFFFFFFF and complete another decoder redirect: the counter holds at 0xFFFFFFFF.
